// File: rtl/game_page_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// game_page_sequencer_pkg
// Shared definitions for the screen/game page sequencer.
//   page_t       : page state codes (START=0, ARM=1, PLAY=2, OVER=3, WON=4).
//                  Codes 5..7 are illegal.
//   PG_W         : width of the page state code.
//   FRAME_CNT_W  : width of the per-frame hold / auto-return counters.
// -----------------------------------------------------------------------------
package game_page_sequencer_pkg;

  localparam int PG_W        = 3;
  localparam int FRAME_CNT_W = 10;

  typedef enum logic [PG_W-1:0] {
    PG_START = 3'd0,
    PG_ARM   = 3'd1,
    PG_PLAY  = 3'd2,
    PG_OVER  = 3'd3,
    PG_WON   = 3'd4
  } page_t;

endpackage

// File: rtl/game_page_sequencer_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// game_page_sequencer_frame_tick_gen
// Produces a one-cycle frame_tick when the raster coordinates arrive at {0,0}
// after having been anywhere else on the previous cycle, giving exactly one
// pulse per frame. Reusable by any logic that steps once per frame.
// Ports:
//   clk        : pixel clock
//   rst        : asynchronous active-high reset
//   pix_x      : current screen X
//   pix_y      : current screen Y
//   frame_tick : one-cycle pulse on the first cycle of each frame
// -----------------------------------------------------------------------------
module game_page_sequencer_frame_tick_gen #(
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic               frame_tick
);

  logic at_origin;
  logic origin_d;

  assign at_origin = (pix_x == '0) && (pix_y == '0);

  // Reset to "was at origin" so that coming out of reset while the raster
  // sits on {0,0} does not produce a spurious tick for a partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      origin_d <= 1'b1;
    end else begin
      origin_d <= at_origin;
    end
  end

  assign frame_tick = at_origin & ~origin_d;

endmodule

// File: rtl/game_page_sequencer.sv
// -----------------------------------------------------------------------------
// game_page_sequencer
// Top-level screen/game sequencer. Chooses which page source feeds the pixel
// path (start page, live game, end page), and gates/resets game_logic so the
// game only runs between a start keypress and a win or loss. Every page change
// happens on frame_tick so no frame mixes two pages.
//
// Optional feature (macro PAGE_AUTO_RET_EN): the end page returns to START by
// itself AUTO_RET_FRAMES frames after entry, unless a valid key comes first.
//
// Ports:
//   vga_clk   : pixel clock (only clock)
//   reset     : asynchronous active-high reset
//   pix_x/y   : raster coordinates from vga_ctrl
//   key_any   : debounced OR of the keys, active high
//   game_over : loss level from game_logic
//   game_won  : win level from game_logic
//   game_rgb  : live game pixel
//   start_rgb : start page pixel
//   end_rgb   : end page pixel
//   pix_data  : selected pixel, registered (1 cycle latency)
//   game_run  : game_logic update enable (PLAY only)
//   game_rst  : game_logic reset (START and ARM)
//   end_won   : end page shows win (1) or lose (0) text
//   page      : current page state code (debug view of the FSM)
// -----------------------------------------------------------------------------
module game_page_sequencer
  import game_page_sequencer_pkg::*;
#(
  parameter int END_HOLD_FRAMES = 60,
  parameter int AUTO_RET_FRAMES = 600,
  parameter int RGB_W           = 16
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             key_any,
  input  logic             game_over,
  input  logic             game_won,
  input  logic [RGB_W-1:0] game_rgb,
  input  logic [RGB_W-1:0] start_rgb,
  input  logic [RGB_W-1:0] end_rgb,
  output logic [RGB_W-1:0] pix_data,
  output logic             game_run,
  output logic             game_rst,
  output logic             end_won,
  output logic [PG_W-1:0]  page
);

  localparam logic [FRAME_CNT_W-1:0] HOLD_INIT = FRAME_CNT_W'(END_HOLD_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] AUTO_INIT = FRAME_CNT_W'(AUTO_RET_FRAMES);

  logic                   frame_tick;
  logic                   key_d;
  logic                   key_evt;
  logic                   key_latch;
  logic                   latch_eff;
  page_t                  state_q, state_d;
  logic [FRAME_CNT_W-1:0] hold_q, hold_d;
  logic                   end_won_q, end_won_d;
  logic [RGB_W-1:0]       pix_d;

`ifdef PAGE_AUTO_RET_EN
  logic [FRAME_CNT_W-1:0] auto_q, auto_d;
`else
  logic [FRAME_CNT_W-1:0] unused_auto_init;
  assign unused_auto_init = AUTO_INIT;
`endif

  game_page_sequencer_frame_tick_gen #(
    .COORD_W (10)
  ) u_frame_tick_gen (
    .clk        (vga_clk),
    .rst        (reset),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_tick (frame_tick)
  );

  // Key edge detection and per-frame latch. An edge landing on the tick cycle
  // itself is folded into latch_eff so it counts for that tick.
  assign key_evt   = key_any & ~key_d;
  assign latch_eff = key_latch | key_evt;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      key_d     <= 1'b0;
      key_latch <= 1'b0;
    end else begin
      key_d <= key_any;
      if (frame_tick) begin
        key_latch <= 1'b0;
      end else if (key_evt) begin
        key_latch <= 1'b1;
      end
    end
  end

  // Page FSM: state register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q   <= PG_START;
      hold_q    <= '0;
      end_won_q <= 1'b0;
      pix_data  <= '0;
`ifdef PAGE_AUTO_RET_EN
      auto_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      end_won_q <= end_won_d;
      pix_data  <= pix_d;
`ifdef PAGE_AUTO_RET_EN
      auto_q    <= auto_d;
`endif
    end
  end

  // Page FSM: next state. Illegal codes fall back to START without waiting
  // for a tick.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    end_won_d = end_won_q;
`ifdef PAGE_AUTO_RET_EN
    auto_d    = auto_q;
`endif
    case (state_q)
      PG_START: begin
        if (frame_tick && latch_eff) state_d = PG_ARM;
      end
      PG_ARM: begin
        if (frame_tick) state_d = PG_PLAY;
      end
      PG_PLAY: begin
        if (frame_tick && (game_won || game_over)) begin
          // Win has priority when both levels are high.
          state_d   = game_won ? PG_WON : PG_OVER;
          end_won_d = game_won;
          hold_d    = HOLD_INIT;
`ifdef PAGE_AUTO_RET_EN
          auto_d    = AUTO_INIT;
`endif
        end
      end
      PG_OVER, PG_WON: begin
        if (frame_tick) begin
          // The pre-decrement hold value gates the key, so a key latched
          // during the last held frame is still discarded.
          if (hold_q != '0) hold_d = hold_q - FRAME_CNT_W'(1);
          if ((hold_q == '0) && latch_eff) state_d = PG_START;
`ifdef PAGE_AUTO_RET_EN
          if (auto_q != '0) auto_d = auto_q - FRAME_CNT_W'(1);
          if (auto_q <= FRAME_CNT_W'(1)) state_d = PG_START;
`endif
        end
      end
      default: begin
        state_d = PG_START;
      end
    endcase
  end

  // Pixel select follows the next state so the first pixel of a new frame
  // already comes from the new page.
  always_comb begin
    pix_d = start_rgb;
    case (state_d)
      PG_START:        pix_d = start_rgb;
      PG_ARM, PG_PLAY: pix_d = game_rgb;
      PG_OVER, PG_WON: pix_d = end_rgb;
      default:         pix_d = start_rgb;
    endcase
  end

  assign game_rst = (state_q == PG_START) || (state_q == PG_ARM);
  assign game_run = (state_q == PG_PLAY);
  assign end_won  = end_won_q;
  assign page     = state_q;

endmodule

// File: tb/tb_game_page_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_page_sequencer
// Drives a small raster (FW x FH pixels per frame) into game_page_sequencer,
// runs the directed start/play/end/reset flow and then a randomized phase.
// A frame-level reference model predicts page, control outputs and the
// selected pixel for every cycle.
// -----------------------------------------------------------------------------
module tb_game_page_sequencer;

  localparam int RGB_W    = 16;
  localparam int END_HOLD = 3;
  localparam int AUTO_RET = 5;
  localparam int FW       = 8;
  localparam int FH       = 4;

  // clock / reset
  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  logic [9:0]       pix_x = 10'd5;
  logic [9:0]       pix_y = 10'd0;
  logic             key_any = 1'b0;
  logic             game_over = 1'b0;
  logic             game_won = 1'b0;
  logic [RGB_W-1:0] game_rgb = 16'h07E0;
  logic [RGB_W-1:0] start_rgb = 16'hF800;
  logic [RGB_W-1:0] end_rgb = 16'h001F;
  logic [RGB_W-1:0] pix_data;
  logic             game_run;
  logic             game_rst;
  logic             end_won;
  logic [2:0]       page;

  game_page_sequencer #(
    .END_HOLD_FRAMES (END_HOLD),
    .AUTO_RET_FRAMES (AUTO_RET),
    .RGB_W           (RGB_W)
  ) dut (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .key_any   (key_any),
    .game_over (game_over),
    .game_won  (game_won),
    .game_rgb  (game_rgb),
    .start_rgb (start_rgb),
    .end_rgb   (end_rgb),
    .pix_data  (pix_data),
    .game_run  (game_run),
    .game_rst  (game_rst),
    .end_won   (end_won),
    .page      (page)
  );

  // scoreboard
  logic [RGB_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model (frame level): 0=start 1=arm 2=play 3=over 4=won
  int m_page, m_hold, m_auto;
  bit m_latch, m_end_won, m_prev_origin, m_prev_key;
  bit rand_mode = 1'b0;

  task automatic model_reset();
    m_page        = 0;
    m_hold        = 0;
    m_auto        = 0;
    m_latch       = 1'b0;
    m_end_won     = 1'b0;
    m_prev_origin = 1'b1;
    m_prev_key    = 1'b0;
  endtask

  task automatic model_update(input bit tick, input bit evt);
    bit pend, leave;
    if (tick) begin
      pend    = m_latch || evt;
      m_latch = 1'b0;
      case (m_page)
        0: if (pend) m_page = 1;
        1: m_page = 2;
        2: begin
          if (game_won || game_over) begin
            m_page    = game_won ? 4 : 3;
            m_end_won = game_won;
            m_hold    = END_HOLD;
            m_auto    = AUTO_RET;
          end
        end
        default: begin
          leave = (m_hold == 0) && pend;
          if (m_hold > 0) m_hold--;
`ifdef PAGE_AUTO_RET_EN
          if (m_auto > 0) m_auto--;
          if (m_auto == 0) leave = 1'b1;
`endif
          if (leave) m_page = 0;
        end
      endcase
    end else if (evt) begin
      m_latch = 1'b1;
    end
  endtask

  // driver: one pixel per cycle, checked #1 after the active edge
  task automatic step(input logic [9:0] x, input logic [9:0] y);
    bit origin, tick, evt;
    logic [RGB_W-1:0] exp_pix;
    if (rand_mode) begin
      game_rgb  = RGB_W'($urandom);
      start_rgb = RGB_W'($urandom);
      end_rgb   = RGB_W'($urandom);
      if ($urandom_range(15) == 0) key_any = ~key_any;
      if ($urandom_range(63) == 0) game_over = ~game_over;
      if ($urandom_range(63) == 0) game_won = ~game_won;
    end
    pix_x  = x;
    pix_y  = y;
    origin = (x == 10'd0) && (y == 10'd0);
    tick   = origin && !m_prev_origin;
    evt    = key_any && !m_prev_key;
    m_prev_origin = origin;
    m_prev_key    = key_any;
    model_update(tick, evt);
    if (m_page == 0)      exp_pix = start_rgb;
    else if (m_page <= 2) exp_pix = game_rgb;
    else                  exp_pix = end_rgb;
    exp_q.push_back(exp_pix);
    @(posedge vga_clk);
    #1;
    check("pix_data", pix_data, exp_q.pop_front());
    check("page", page, m_page);
    check("game_rst", game_rst, m_page <= 1);
    check("game_run", game_run, m_page == 2);
    check("end_won", end_won, m_end_won);
  endtask

  // press_idx < 0: no key; otherwise key rises at that pixel for 3 cycles
  task automatic run_frames(input int n, input int press_idx);
    for (int f = 0; f < n; f++) begin
      for (int y = 0; y < FH; y++) begin
        for (int x = 0; x < FW; x++) begin
          if (press_idx >= 0 && (y * FW + x) == press_idx)     key_any = 1'b1;
          if (press_idx >= 0 && (y * FW + x) == press_idx + 3) key_any = 1'b0;
          step(10'(x), 10'(y));
        end
      end
    end
  endtask

  task automatic goto_play();
    for (int i = 0; i < 8 && m_page != 2; i++) run_frames(1, 10);
    check("reach_play", page, 3'd2);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_page", page, 3'd0);
    check("rst_game_rst", game_rst, 1'b1);
    check("rst_game_run", game_run, 1'b0);
    check("rst_pix", pix_data, 16'h0000);
    check("rst_end_won", end_won, 1'b0);
    reset = 1'b0;

    // idle start page, then key mid-frame -> ARM -> PLAY
    run_frames(3, -1);
    check("idle_page", page, 3'd0);
    run_frames(1, 10);
    run_frames(1, -1);
    check("arm_page", page, 3'd1);
    check("arm_game_rst", game_rst, 1'b1);
    run_frames(1, -1);
    check("play_page", page, 3'd2);
    check("play_pix", pix_data, 16'h07E0);

    // simultaneous win and loss: win has priority
    game_over = 1'b1;
    game_won  = 1'b1;
    run_frames(1, -1);
    check("won_page", page, 3'd4);
    check("won_flag", end_won, 1'b1);
    check("won_pix", pix_data, 16'h001F);
    game_over = 1'b0;
    game_won  = 1'b0;

    // key during hold is dropped; key after hold expiry returns to START
    run_frames(1, 10);
    run_frames(1, -1);
    check("hold_ignore", page, 3'd4);
    run_frames(1, 10);
    check("hold_wait", page, 3'd4);
    run_frames(1, -1);
    check("key_return", page, 3'd0);

    // loss with no keys: auto return or stay
    goto_play();
    game_over = 1'b1;
    run_frames(1, -1);
    check("over_page", page, 3'd3);
    check("over_flag", end_won, 1'b0);
    game_over = 1'b0;
    run_frames(4, -1);
    check("over_t4", page, 3'd3);
    run_frames(1, -1);
`ifdef PAGE_AUTO_RET_EN
    check("auto_ret", page, 3'd0);
`else
    check("stay_over", page, 3'd3);
`endif
    run_frames(3, -1);

    // asynchronous reset in the middle of a PLAY line
    goto_play();
    for (int i = 0; i < 13; i++) step(10'(i % FW), 10'(i / FW));
    key_any = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_page", page, 3'd0);
    check("mid_rst_game_rst", game_rst, 1'b1);
    check("mid_rst_game_run", game_run, 1'b0);
    check("mid_rst_pix", pix_data, 16'h0000);
    model_reset();
    exp_q.delete();
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1;
    reset = 1'b0;
    goto_play();

    // randomized phase
    rand_mode = 1'b1;
    run_frames(40, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
